// File: rtl/fpu_core.sv
// Purpose: binary32 add/sub/mul/div unit that runs continuously: it samples A, B and the operator, computes, publishes, then samples again.
// Latency: a fixed 28-cycle period for every operator. The capture edge is k, the result lands at edge k+27, and the next capture is at k+28.
// Backpressure: none. m_axis_result_tvalid is a one-cycle strobe and there is no downstream ready.
// Ports: clk/rst (synchronous, active-high), A/B operands, operator (00 add, 01 sub, 02 mul, 03 div),
//        result (registered, held between strobes), m_axis_result_tvalid (new-result strobe).
module fpu_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [7:0]  operator,
    output logic [31:0] result,
    output logic        m_axis_result_tvalid
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] a_q, b_q;
    logic [7:0]  op_q;
    logic [25:0] rem_q;
    logic [25:0] quo_q;
    logic [31:0] res_comb;

    // ------------------------------------------------------------------
    // Operand decode (works on the captured copies only)
    // ------------------------------------------------------------------
    logic        sa, sb, sb_add;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        za, zb, ia, ib, na, nb;
    logic [23:0] ma, mb;

    assign sa = a_q[31];
    assign sb = b_q[31];
    assign ea = a_q[30:23];
    assign eb = b_q[30:23];
    assign fa = a_q[22:0];
    assign fb = b_q[22:0];
    assign za = (ea == 8'd0);              // zero and denormals alike
    assign zb = (eb == 8'd0);
    assign ia = (ea == 8'hFF) && (fa == 23'd0);
    assign ib = (eb == 8'hFF) && (fb == 23'd0);
    assign na = (ea == 8'hFF) && (fa != 23'd0);
    assign nb = (eb == 8'hFF) && (fb != 23'd0);
    assign ma = za ? 24'd0 : {1'b1, fa};
    assign mb = zb ? 24'd0 : {1'b1, fb};
    assign sb_add = sb ^ (op_q == 8'h01);  // subtract is add with B negated

    // Saturating exponent/mantissa packer shared by every arithmetic path.
    function automatic logic [31:0] pack(input logic s, input logic signed [10:0] e,
                                         input logic [23:0] m);
        logic [31:0] r;
        if (e >= 11'sd255)
            r = {s, 8'hFF, 23'd0};
        else if (e <= 11'sd0)
            r = {s, 31'd0};
        else
            r = {s, e[7:0], m[22:0]};
        return r;
    endfunction

    function automatic logic [5:0] clz48(input logic [47:0] v);
        logic [5:0] n;
        n = 6'd48;
        for (int i = 0; i < 48; i++)
            if (v[i]) n = 6'(47 - i);
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Add / subtract
    // ------------------------------------------------------------------
    logic        a_big, eff_sub, big_s, sticky;
    logic [7:0]  big_e, sml_e, dexp;
    logic [23:0] big_m, sml_m;
    logic [71:0] sml_sh;
    logic [47:0] sml_al;
    logic [48:0] sum;
    logic [5:0]  lz;
    logic [47:0] norm;
    logic signed [10:0] e_add;
    logic [23:0] m_add;

    assign a_big   = (a_q[30:0] >= b_q[30:0]);
    assign big_e   = a_big ? ea : eb;
    assign sml_e   = a_big ? eb : ea;
    assign big_m   = a_big ? ma : mb;
    assign sml_m   = a_big ? mb : ma;
    assign big_s   = a_big ? sa : sb_add;
    assign eff_sub = sa ^ sb_add;
    assign dexp    = big_e - sml_e;

    // The smaller operand is carried with 24 extra fraction bits. Anything
    // shifted past them collapses into sticky. Sticky only matters when
    // subtracting: it makes the integer difference the floor of the exact
    // one, which is what truncation wants.
    assign sml_sh = {sml_m, 48'd0} >> dexp;
    assign sml_al = sml_sh[71:24];
    assign sticky = (dexp >= 8'd48) ? (|sml_m) : (|sml_sh[23:0]);

    assign sum = eff_sub ? ({1'b0, big_m, 24'd0} - {1'b0, sml_al} - {48'd0, sticky})
                         : ({1'b0, big_m, 24'd0} + {1'b0, sml_al});

    assign lz    = clz48(sum[47:0]);
    assign norm  = sum[47:0] << lz;
    assign e_add = sum[48] ? $signed({3'b000, big_e}) + 11'sd1
                           : $signed({3'b000, big_e}) - $signed({5'b00000, lz});
    assign m_add = sum[48] ? sum[48:25] : norm[47:24];

    // ------------------------------------------------------------------
    // Multiply
    // ------------------------------------------------------------------
    logic [47:0] prod;
    logic signed [10:0] e_mul;
    logic [23:0] m_mul;

    assign prod  = ma * mb;
    assign e_mul = $signed({3'b000, ea}) + $signed({3'b000, eb}) - 11'sd127
                   + (prod[47] ? 11'sd1 : 11'sd0);
    assign m_mul = prod[47] ? prod[47:24] : prod[46:23];

    // ------------------------------------------------------------------
    // Divide: quotient bits come from the iterative register. quo_q[25]
    // has weight 2^0, so a 0 there means the ratio was below 1.
    // ------------------------------------------------------------------
    logic signed [10:0] e_div;
    logic [23:0] m_div;

    assign e_div = $signed({3'b000, ea}) - $signed({3'b000, eb}) + 11'sd127
                   - (quo_q[25] ? 11'sd0 : 11'sd1);
    assign m_div = quo_q[25] ? quo_q[25:2] : quo_q[24:1];

    // Bits that are dropped by truncation
    logic unused_bits;
    assign unused_bits = ^{quo_q[0], prod[22:0], norm[23:0]};

    // ------------------------------------------------------------------
    // Result select including special operands
    // ------------------------------------------------------------------
    always_comb begin
        res_comb = QNAN;
        case (op_q)
            8'h00, 8'h01: begin
                if (na || nb)
                    res_comb = QNAN;
                else if (ia && ib)
                    res_comb = eff_sub ? QNAN : {sa, 8'hFF, 23'd0};
                else if (ia)
                    res_comb = {sa, 8'hFF, 23'd0};
                else if (ib)
                    res_comb = {sb_add, 8'hFF, 23'd0};
                else if (za && zb)
                    res_comb = {sa & sb_add, 31'd0};
                else if (za)
                    res_comb = {sb_add, b_q[30:0]};
                else if (zb)
                    res_comb = a_q;
                else if (sum == 49'd0)
                    res_comb = 32'h00000000;
                else
                    res_comb = pack(big_s, e_add, m_add);
            end
            8'h02: begin
                if (na || nb || (ia && zb) || (za && ib))
                    res_comb = QNAN;
                else if (ia || ib)
                    res_comb = {sa ^ sb, 8'hFF, 23'd0};
                else if (za || zb)
                    res_comb = {sa ^ sb, 31'd0};
                else
                    res_comb = pack(sa ^ sb, e_mul, m_mul);
            end
            8'h03: begin
                if (na || nb || (za && zb) || (ia && ib))
                    res_comb = QNAN;
                else if (ia)
                    res_comb = {sa ^ sb, 8'hFF, 23'd0};
                else if (ib)
                    res_comb = {sa ^ sb, 31'd0};
                else if (zb)
                    res_comb = {sa ^ sb, 8'hFF, 23'd0};
                else if (za)
                    res_comb = {sa ^ sb, 31'd0};
                else
                    res_comb = pack(sa ^ sb, e_div, m_div);
            end
            default: res_comb = QNAN;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer and iterative divider
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_LOAD;
            cnt                  <= 5'd0;
            a_q                  <= 32'd0;
            b_q                  <= 32'd0;
            op_q                 <= 8'd0;
            rem_q                <= 26'd0;
            quo_q                <= 26'd0;
            result               <= 32'd0;
            m_axis_result_tvalid <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    m_axis_result_tvalid <= 1'b0;
                    a_q   <= A;
                    b_q   <= B;
                    op_q  <= operator;
                    // Partial remainder starts as A's mantissa (0 for a flushed A)
                    rem_q <= {2'b00, (A[30:23] != 8'd0), (A[30:23] != 8'd0) ? A[22:0] : 23'd0};
                    quo_q <= 26'd0;
                    cnt   <= 5'd0;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    // One restoring step per cycle, 26 quotient bits in total
                    if (rem_q >= {2'b00, mb}) begin
                        rem_q <= (rem_q - {2'b00, mb}) << 1;
                        quo_q <= {quo_q[24:0], 1'b1};
                    end else begin
                        rem_q <= rem_q << 1;
                        quo_q <= {quo_q[24:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd25)
                        state <= S_DONE;
                end
                S_DONE: begin
                    result               <= res_comb;
                    m_axis_result_tvalid <= 1'b1;
                    state                <= S_LOAD;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_core.sv
// Purpose: directed-vector bench for fpu_core with hand-computed binary32 results and period checks.
// Latency: expects the strobe 28 edges after the previous one, or 27 edges after the first capture.
// Backpressure: none to model. Inputs are changed right after a strobe, ahead of the next capture edge.
module tb_fpu_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [7:0]  op = 8'd0;
    logic [31:0] result;
    logic        tvalid;

    int checks = 0;
    int errors = 0;

    fpu_core dut (
        .clk                  (clk),
        .rst                  (rst),
        .A                    (a),
        .B                    (b),
        .operator             (op),
        .result               (result),
        .m_axis_result_tvalid (tvalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Count rising edges until the strobe is seen (sampled 1 time unit after each edge).
    task automatic wait_strobe(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!tvalid && n < 64);
    endtask

    // Call right after a strobe: the next edge captures these inputs.
    task automatic run(input string tag, input logic [31:0] va, input logic [31:0] vb,
                       input logic [7:0] vo, input logic [31:0] exp);
        int n;
        a  = va;
        b  = vb;
        op = vo;
        wait_strobe(n);
        check({tag, " period"}, n, 32'd28);
        check(tag, result, exp);
    endtask

    initial begin
        int n;
        a  = 32'h40C8F5C3;
        b  = 32'h40C8F5C3;
        op = 8'h03;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", result, 32'h0);
        check("reset strobe", {31'd0, tvalid}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        wait_strobe(n);
        check("first strobe edge", n, 32'd28);
        check("div 6.28/6.28", result, 32'h3F800000);

        // The strobe lasts one cycle, then repeats with the same value.
        @(posedge clk);
        #1;
        check("strobe one cycle", {31'd0, tvalid}, 32'd0);
        wait_strobe(n);
        check("repeat period", n, 32'd27);
        check("repeat value", result, 32'h3F800000);

        run("add 6.28+6.28",   32'h40C8F5C3, 32'h40C8F5C3, 8'h00, 32'h4148F5C3);
        run("sub 6.28-6.28",   32'h40C8F5C3, 32'h40C8F5C3, 8'h01, 32'h00000000);
        run("mul 2*3",         32'h40000000, 32'h40400000, 8'h02, 32'h40C00000);
        run("mul 1.5*1.5",     32'h3FC00000, 32'h3FC00000, 8'h02, 32'h40100000);
        run("div 1/1.5 trunc", 32'h3F800000, 32'h3FC00000, 8'h03, 32'h3F2AAAAA);
        run("sub 1-2^-30",     32'h3F800000, 32'h30800000, 8'h01, 32'h3F7FFFFF);
        run("add 1+2^-30",     32'h3F800000, 32'h30800000, 8'h00, 32'h3F800000);
        run("add -0+-0",       32'h80000000, 32'h80000000, 8'h00, 32'h80000000);
        run("add denorm+1",    32'h00000001, 32'h3F800000, 8'h00, 32'h3F800000);
        run("div 1/0",         32'h3F800000, 32'h00000000, 8'h03, 32'h7F800000);
        run("sub inf-inf",     32'h7F800000, 32'h7F800000, 8'h01, 32'h7FC00000);
        run("mul overflow",    32'h7F000000, 32'h7F000000, 8'h02, 32'h7F800000);
        run("mul underflow",   32'h00800000, 32'h00800000, 8'h02, 32'h00000000);
        run("mul 0*inf",       32'h00000000, 32'h7F800000, 8'h02, 32'h7FC00000);
        run("div -1/inf",      32'hBF800000, 32'h7F800000, 8'h03, 32'h80000000);
        run("add -inf+1",      32'hFF800000, 32'h3F800000, 8'h00, 32'hFF800000);
        run("add nan+1",       32'h7FC00001, 32'h3F800000, 8'h00, 32'h7FC00000);

        // Operands change mid-EXEC. The captured 2*3 must win.
        a  = 32'h40000000;
        b  = 32'h40400000;
        op = 8'h02;
        repeat (5) @(posedge clk);
        #1;
        a  = 32'h3F800000;
        b  = 32'h3F800000;
        op = 8'h00;
        wait_strobe(n);
        check("midexec change period", n, 32'd23);
        check("midexec change value", result, 32'h40C00000);

        // One-cycle reset mid-EXEC discards the operation and restarts the period.
        a  = 32'h40C8F5C3;
        b  = 32'h40C8F5C3;
        op = 8'h00;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midexec reset result", result, 32'h0);
        check("midexec reset strobe", {31'd0, tvalid}, 32'd0);
        rst = 1'b0;
        wait_strobe(n);
        check("post reset period", n, 32'd28);
        check("post reset value", result, 32'h4148F5C3);

        run("invalid op 0x07", 32'h3F800000, 32'h3F800000, 8'h07, 32'h7FC00000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_core.md
# fpu_core

Single-precision (IEEE-754 binary32) floating-point arithmetic unit performing add, subtract, multiply and divide on two 32-bit operands selected by an 8-bit operator code. Free-running: it samples its inputs, computes over a fixed 28-cycle period, publishes the result with a one-cycle valid strobe, then samples again. It is a self-contained datapath block for the SEA-S7 system, with no external IP dependency.

## Interface
- No parameters.
- Clock and reset: one clock; reset is synchronous and active-high.
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- A  input  32  operand A, binary32.
- B  input  32  operand B, binary32.
- operator  input  8  opcode:
  - 0x00 = A+B; 0x01 = A−B; 0x02 = A×B; 0x03 = A÷B.
  - Any other value is invalid.
- result  output  32  registered binary32 result; holds its value between updates.
- m_axis_result_tvalid  output  1  one-cycle strobe marking a new result.

## Operation
- FSM states: LOAD, EXEC, DONE.
  - LOAD: capture A, B and operator into internal registers, then go to EXEC.
  - EXEC: runs for 26 cycles. The divider performs one restoring mantissa-quotient step per cycle (26 quotient bits). Add/sub/mul results are computed during EXEC and held.
  - DONE: write result, assert m_axis_result_tvalid, then go to LOAD.
- Inputs are only sampled in LOAD; changes at any other time are ignored until the next LOAD.
- Operand decode:
  - Exponent 0 means zero (denormals are flushed to signed zero on input).
  - Exponent 255 with mantissa 0 is ±inf; exponent 255 with mantissa ≠ 0 is NaN.
- Add/sub:
  - Subtract is add with B's sign inverted.
  - Align the smaller operand by right shift, keeping guard/sticky bits.
  - Add or subtract magnitudes, normalize with a leading-zero shift, then round.
  - An exact zero result is +0, except (−0)+(−0) = −0.
- Multiply:
  - Sign = sA^sB; exponent = eA+eB−127.
  - 24×24 mantissa product, normalize by 0 or 1 position, then round.
- Divide:
  - Sign = sA^sB; exponent = eA−eB+127.
  - Restoring division of the 24-bit mantissas, normalize, then round.
- Rounding: round toward zero (truncate) for all ops.
- Range:
  - Biased exponent ≥ 255 after normalization gives ±inf (0x7F800000 | sign).
  - Biased exponent ≤ 0 flushes to signed zero.
- Special cases:
  - Any NaN input gives 0x7FC00000.
  - inf−inf (effective), 0×inf, 0÷0 and inf÷inf give 0x7FC00000.
  - Finite÷0 gives signed inf; finite÷inf gives signed zero.
  - inf op finite propagates inf with the correct sign.
- Invalid operator: result = 0x7FC00000; the strobe still fires on schedule.

## Timing
- Reset (synchronous, any state, including mid-operation):
  - result = 0x00000000, m_axis_result_tvalid = 0, state = LOAD.
  - Any in-flight operation is discarded.
- Let edge k be a LOAD capture:
  - EXEC occupies edges k+1..k+26.
  - At edge k+27, result is updated and m_axis_result_tvalid goes high.
  - At edge k+28, m_axis_result_tvalid goes low and the next capture occurs.
- Period: exactly 28 cycles, the same for every operator.
- Strobe: high for exactly 1 cycle per period and never high in two consecutive cycles.
- First capture: the first rising edge with rst low; the first strobe follows 27 edges later.
- Output stability: result changes only at DONE edges or on reset.
- No back-pressure; there is no downstream ready signal.

## Test plan
- A=B=0x40C8F5C3 (6.28), operator=0x03, after reset deasserts:
  - Strobe at edge 27, result=0x3F800000.
  - Strobe repeats every 28 cycles with the same value.
- Same operands, operator=0x00 → 0x4148F5C3; operator=0x01 → 0x00000000.
- Multiply: A=0x40000000, B=0x40400000, operator=0x02 → 0x40C00000.
- Special cases:
  - A=0x3F800000 ÷ B=0x00000000 → 0x7F800000.
  - A=0x7F800000 − B=0x7F800000 → 0x7FC00000.
  - A=B=0x7F000000 multiplied → 0x7F800000.
- Change operands mid-EXEC: the result reflects the captured values, not the new ones.
- Assert rst for 1 cycle mid-EXEC:
  - result=0 and strobe=0 on the next cycle.
  - No stale strobe.
  - A fresh 28-cycle period then begins.
- operator=0x07 → 0x7FC00000, with the strobe still on schedule.
